valu_seq: RTL and testbench
===========================

VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- NUM_ELEM, 16, maximum vector length in elements (power of 2, at least 2).
- LANES, 4, elements issued per beat (power of 2, at most NUM_ELEM).
- IDX_W, $clog2(NUM_ELEM), element index width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports are listed one per line (name, direction, width, meaning):
- clk_i, in, 1, clock; all state updates on its rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- req_valid_i, in, 1, a vector op request is presented.
- req_ready_o, out, 1, the block can accept a request.
- vfunct_i, in, 10, {funct6, vm, funct3} of the request.
- vl_i, in, IDX_W+1, requested active vector length.
- mask_i, in, NUM_ELEM, element mask; present only under VALU_SEQ_MASK_EN.
- beat_valid_o, out, 1, a beat is presented.
- beat_ready_i, in, 1, the datapath accepts the beat.
- beat_idx_o, out, IDX_W, index of lane 0 of the beat.
- lane_en_o, out, LANES, per-lane enable.
- valu_ctrl_o, out, 3, ALU control code for the beat.
- acc_clr_o, out, 1, first beat of a dot product.
- reduce_o, out, 1, last beat of a dot product.
- done_o, out, 1, one-cycle completion pulse.
- illegal_o, out, 1, one-cycle illegal-op pulse.

Function
REQ-003 Decode SHALL be as follows: 000000_1_001 -> 3'b010 (add); 010000_1_000 -> 3'b110 (sub); 000000_1_111 -> 3'b000 (scalar mul); 000000_1_110 -> 3'b001 (dot). Any other code is illegal.
REQ-004 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-005 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o.
REQ-006 On accept, the block SHALL register vfunct_i, vl_i (and mask_i), and compute the effective length vl_eff = min(vl_i, NUM_ELEM).
REQ-007 On accept of a legal op with vl_eff > 0: IDLE -> RUN, and beat_valid_o SHALL rise in the next cycle with beat_idx_o = 0.
REQ-008 In RUN, beat outputs SHALL hold stable while beat_valid_o && !beat_ready_i.
REQ-009 On each beat handshake, beat_idx_o SHALL advance by LANES.
REQ-010 Number of beats = ceil(vl_eff/LANES); lane_en_o[k] = (beat_idx_o + k < vl_eff).
REQ-011 On the handshake of the final beat: RUN -> DONE.
REQ-012 In DONE, done_o SHALL be 1 for one cycle, then the state returns to IDLE.
REQ-013 For the dot op, acc_clr_o SHALL be 1 on the first beat only and reduce_o on the final beat only. A single-beat dot asserts both. For other ops both are 0.
REQ-014 An accepted legal op with vl_eff = 0 SHALL go IDLE -> DONE with no beats.
REQ-015 An accepted illegal op SHALL go IDLE -> DONE with no beats; illegal_o and done_o are both 1 in that DONE cycle.
REQ-016 valu_ctrl_o SHALL be 3'b000 whenever beat_valid_o = 0.
REQ-017 beat_ready_i SHALL be ignored while beat_valid_o = 0.
REQ-018 A req_valid_i asserted outside IDLE SHALL be held off by req_ready_o = 0; there are no back-to-back accepts, so at least one IDLE cycle separates ops.

Reset
REQ-019 rst_i SHALL asynchronously force IDLE, including when asserted mid-RUN; the in-flight op is discarded without done_o.
REQ-020 Output values during reset SHALL be: req_ready_o = 0; beat_valid_o, lane_en_o, valu_ctrl_o, acc_clr_o, reduce_o, done_o, illegal_o = 0; beat_idx_o = 0.
REQ-021 req_ready_o SHALL go to 1 in the first clock cycle after rst_i deasserts.

Configuration
REQ-022 Macro VALU_SEQ_MASK_EN defined: mask_i SHALL exist, and vm = 0 variants of the four codes are legal with the same ctrl. For those, lane_en_o[k] is additionally ANDed with the registered mask bit [beat_idx_o + k]. Beats with all lanes masked are still issued.
REQ-023 Macro VALU_SEQ_MASK_EN undefined: mask_i SHALL be absent and any vm = 0 code is illegal.

Verification
REQ-024 With NUM_ELEM=16 and LANES=4, add with vl=10 and beat_ready_i held at 1 -> beats idx 0/4/8, lane_en 1111/1111/0011, ctrl 010, done_o in the cycle after the third beat.
REQ-025 Dot with vl=4 -> one beat with acc_clr_o = reduce_o = 1 and ctrl 001. Dot with vl=16 and beat_ready_i low for 2 cycles on beat 2 -> outputs held, 4 beats, reduce_o on idx 12 only.
REQ-026 Code 000001_1_000 -> no beats, illegal_o and done_o pulse 1 cycle after accept. vl=0 with sub -> done_o only. vl=20 -> clamped to 4 beats.
REQ-027 rst_i asserted during beat idx 8 of a vl=16 add -> outputs 0 immediately, no done_o, req_ready_o = 1 in the first cycle after release.
REQ-028 With VALU_SEQ_MASK_EN defined: vm=0 add, vl=8, mask=16'h00F0 -> lane_en 0000 then 1111. With it undefined, the same code -> illegal_o.

Source files
------------

// File: rtl/valu_seq.sv
// Vector ALU beat sequencer: decodes a vector op and issues LANES-wide beats up to vl.
// Optional per-element masking (vm = 0 codes) is enabled by defining VALU_SEQ_MASK_EN.

module valu_lane #(
  parameter int NUM_ELEM = 16,
  parameter int IDX_W    = 4,
  parameter int LANE     = 0
) (
  input  logic [IDX_W:0]    idx,
  input  logic [IDX_W:0]    vl,
`ifdef VALU_SEQ_MASK_EN
  input  logic              use_mask,
  input  logic [NUM_ELEM-1:0] mask,
`endif
  output logic              en
);
  logic [IDX_W:0] pos;

  assign pos = idx + (IDX_W+1)'(LANE);
`ifdef VALU_SEQ_MASK_EN
  // pos past NUM_ELEM wraps the mask index, but the vl compare already kills that lane
  assign en  = (pos < vl) && (!use_mask || mask[pos[IDX_W-1:0]]);
`else
  assign en  = (pos < vl);
`endif
endmodule

module valu_seq #(
  parameter int NUM_ELEM = 16,
  parameter int LANES    = 4,
  parameter int IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [9:0]          vfunct_i,
  input  logic [IDX_W:0]      vl_i,
`ifdef VALU_SEQ_MASK_EN
  input  logic [NUM_ELEM-1:0] mask_i,
`endif
  output logic                beat_valid_o,
  input  logic                beat_ready_i,
  output logic [IDX_W-1:0]    beat_idx_o,
  output logic [LANES-1:0]    lane_en_o,
  output logic [2:0]          valu_ctrl_o,
  output logic                acc_clr_o,
  output logic                reduce_o,
  output logic                done_o,
  output logic                illegal_o
);
  localparam logic [IDX_W:0] NE = (IDX_W+1)'(NUM_ELEM);
  localparam logic [IDX_W:0] LN = (IDX_W+1)'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [5:0] funct6;
    logic       vm;
    logic [2:0] funct3;
  } vfunct_t;

  vfunct_t        req;
  state_t         state_q, state_d;
  logic [2:0]     ctrl_q, dec_ctrl;
  logic           dot_q, dec_dot, ill_q, dec_legal;
  logic [IDX_W:0] vl_q, idx_q, vl_eff;
  logic           accept, beat_hs, last_beat;
  logic [LANES-1:0] lane_raw;
`ifdef VALU_SEQ_MASK_EN
  logic [NUM_ELEM-1:0] mask_q;
  logic                use_mask_q;
`endif

  assign req    = vfunct_i;
  assign vl_eff = (vl_i > NE) ? NE : vl_i;

  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 3'b000;
    dec_dot   = 1'b0;
    case ({req.funct6, req.funct3})
      9'b000000_001: dec_ctrl = 3'b010;
      9'b010000_000: dec_ctrl = 3'b110;
      9'b000000_111: dec_ctrl = 3'b000;
      9'b000000_110: begin dec_ctrl = 3'b001; dec_dot = 1'b1; end
      default:       dec_legal = 1'b0;
    endcase
`ifndef VALU_SEQ_MASK_EN
    if (!req.vm) dec_legal = 1'b0;
`endif
  end

  assign accept    = req_valid_i && req_ready_o;
  assign beat_hs   = (state_q == RUN) && beat_ready_i;
  assign last_beat = (idx_q + LN) >= vl_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      dot_q   <= 1'b0;
      ill_q   <= 1'b0;
      vl_q    <= '0;
      idx_q   <= '0;
`ifdef VALU_SEQ_MASK_EN
      mask_q     <= '0;
      use_mask_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q <= dec_ctrl;
        dot_q  <= dec_dot;
        ill_q  <= !dec_legal;
        vl_q   <= vl_eff;
        idx_q  <= '0;
`ifdef VALU_SEQ_MASK_EN
        mask_q     <= mask_i;
        use_mask_q <= !req.vm;
`endif
      end else if (beat_hs) begin
        idx_q <= idx_q + LN;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    valu_lane #(.NUM_ELEM(NUM_ELEM), .IDX_W(IDX_W), .LANE(k)) u_lane (
      .idx      (idx_q),
      .vl       (vl_q),
`ifdef VALU_SEQ_MASK_EN
      .use_mask (use_mask_q),
      .mask     (mask_q),
`endif
      .en       (lane_raw[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    beat_valid_o = 1'b0;
    lane_en_o    = '0;
    valu_ctrl_o  = 3'b000;
    acc_clr_o    = 1'b0;
    reduce_o     = 1'b0;
    done_o       = 1'b0;
    illegal_o    = 1'b0;
    beat_idx_o   = idx_q[IDX_W-1:0];
    case (state_q)
      IDLE: begin
        // held low while reset is asserted, high as soon as it releases
        req_ready_o = !rst_i;
        beat_idx_o  = '0;
        if (accept) state_d = (!dec_legal || vl_eff == '0) ? DONE : RUN;
      end
      RUN: begin
        beat_valid_o = 1'b1;
        lane_en_o    = lane_raw;
        valu_ctrl_o  = ctrl_q;
        acc_clr_o    = dot_q && (idx_q == '0);
        reduce_o     = dot_q && last_beat;
        if (beat_ready_i && last_beat) state_d = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        illegal_o  = ill_q;
        beat_idx_o = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_valu_seq.sv
// Scoreboard bench for valu_seq: driver pushes expected beats/done, negedge monitor pops and compares.
module tb_valu_seq;
  localparam int NUM_ELEM = 16;
  localparam int LANES    = 4;
  localparam int IDX_W    = 4;

  localparam logic [9:0] F_ADD  = 10'b000000_1_001;
  localparam logic [9:0] F_SUB  = 10'b010000_1_000;
  localparam logic [9:0] F_MUL  = 10'b000000_1_111;
  localparam logic [9:0] F_DOT  = 10'b000000_1_110;
  localparam logic [9:0] F_ILL  = 10'b000001_1_000;
  localparam logic [9:0] F_ADDM = 10'b000000_0_001;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, beat_ready_i = 1'b1;
  logic [9:0] vfunct_i = '0;
  logic [IDX_W:0] vl_i = '0;
`ifdef VALU_SEQ_MASK_EN
  logic [NUM_ELEM-1:0] mask_i = '0;
`endif
  logic req_ready_o, beat_valid_o, acc_clr_o, reduce_o, done_o, illegal_o;
  logic [IDX_W-1:0] beat_idx_o;
  logic [LANES-1:0] lane_en_o;
  logic [2:0] valu_ctrl_o;

  valu_seq #(.NUM_ELEM(NUM_ELEM), .LANES(LANES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .vfunct_i(vfunct_i), .vl_i(vl_i),
`ifdef VALU_SEQ_MASK_EN
    .mask_i(mask_i),
`endif
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i), .beat_idx_o(beat_idx_o),
    .lane_en_o(lane_en_o), .valu_ctrl_o(valu_ctrl_o), .acc_clr_o(acc_clr_o),
    .reduce_o(reduce_o), .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         is_done;
    bit         ill;
    logic [3:0] idx;
    logic [3:0] en;
    logic [2:0] ctrl;
    bit         acc;
    bit         red;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pb(logic [3:0] idx, logic [3:0] en, logic [2:0] ctrl, bit acc, bit red);
    exp_t e;
    e.is_done = 0; e.ill = 0; e.idx = idx; e.en = en; e.ctrl = ctrl; e.acc = acc; e.red = red;
    sb.push_back(e);
  endtask

  task automatic pd(bit ill);
    exp_t e;
    e.is_done = 1; e.ill = ill; e.idx = 0; e.en = 0; e.ctrl = 0; e.acc = 0; e.red = 0;
    sb.push_back(e);
  endtask

  // monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (!beat_valid_o && valu_ctrl_o != 3'b000) chk("ctrl_idle_zero", 32'(valu_ctrl_o), 0);
      if (beat_valid_o) begin
        if (sb.size() == 0 || sb[0].is_done) chk("unexpected_beat", 32'(beat_idx_o), 32'hFFFF);
        else begin
          chk("beat_idx",  32'(beat_idx_o),  32'(sb[0].idx));
          chk("lane_en",   32'(lane_en_o),   32'(sb[0].en));
          chk("ctrl",      32'(valu_ctrl_o), 32'(sb[0].ctrl));
          chk("acc_clr",   32'(acc_clr_o),   32'(sb[0].acc));
          chk("reduce",    32'(reduce_o),    32'(sb[0].red));
          chk("ready_run", 32'(req_ready_o), 0);
          if (beat_ready_i) void'(sb.pop_front());
        end
      end
      if (done_o) begin
        if (sb.size() == 0 || !sb[0].is_done) chk("unexpected_done", 1, 0);
        else begin
          chk("illegal", 32'(illegal_o), 32'(sb[0].ill));
          void'(sb.pop_front());
        end
      end else if (illegal_o) chk("illegal_no_done", 1, 0);
    end
  end

  // issue one op; ready drops for sn cycles starting at cycle sf after accept
  task automatic run(logic [9:0] f, logic [IDX_W:0] vl, int sf, int sn, int exp_cnt);
    int cnt, w;
    w = 0;
    while (!req_ready_o && w < 50) begin @(posedge clk_i); #1; w++; end
    if (w >= 50) chk("ready_timeout", 0, 1);
    req_valid_i = 1'b1; vfunct_i = f; vl_i = vl;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      cnt++;
      beat_ready_i = !(sn > 0 && cnt >= sf && cnt < sf + sn);
      @(negedge clk_i);
      if (done_o) break;
      @(posedge clk_i); #1;
    end
    chk("done_latency", 32'(cnt), 32'(exp_cnt));
    @(posedge clk_i); #1;
    beat_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #1;
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_outs", 32'({beat_valid_o, lane_en_o, valu_ctrl_o, acc_clr_o, reduce_o, done_o, illegal_o, beat_idx_o}), 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready_o), 1);
    @(posedge clk_i); #1;

    // add vl=10
    pb(0, 4'hF, 3'b010, 0, 0); pb(4, 4'hF, 3'b010, 0, 0); pb(8, 4'h3, 3'b010, 0, 0); pd(0);
    run(F_ADD, 5'd10, 0, 0, 4);
    // single-beat dot
    pb(0, 4'hF, 3'b001, 1, 1); pd(0);
    run(F_DOT, 5'd4, 0, 0, 2);
    // dot vl=16 with 2-cycle stall on the second beat
    pb(0, 4'hF, 3'b001, 1, 0); pb(4, 4'hF, 3'b001, 0, 0);
    pb(8, 4'hF, 3'b001, 0, 0); pb(12, 4'hF, 3'b001, 0, 1); pd(0);
    run(F_DOT, 5'd16, 2, 2, 7);
    // illegal code
    pd(1);
    run(F_ILL, 5'd8, 0, 0, 1);
    // zero length
    pd(0);
    run(F_SUB, 5'd0, 0, 0, 1);
    // vl=20 clamps to 16
    pb(0, 4'hF, 3'b000, 0, 0); pb(4, 4'hF, 3'b000, 0, 0);
    pb(8, 4'hF, 3'b000, 0, 0); pb(12, 4'hF, 3'b000, 0, 0); pd(0);
    run(F_MUL, 5'd20, 0, 0, 5);
    // dot vl=6: partial last beat
    pb(0, 4'hF, 3'b001, 1, 0); pb(4, 4'h3, 3'b001, 0, 1); pd(0);
    run(F_DOT, 5'd6, 0, 0, 3);
    // sub vl=1
    pb(0, 4'h1, 3'b110, 0, 0); pd(0);
    run(F_SUB, 5'd1, 0, 0, 2);

    // reset during beat idx 8 of vl=16 add
    pb(0, 4'hF, 3'b010, 0, 0); pb(4, 4'hF, 3'b010, 0, 0); pb(8, 4'hF, 3'b010, 0, 0);
    req_valid_i = 1'b1; vfunct_i = F_ADD; vl_i = 5'd16;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    w = 0;
    do begin @(negedge clk_i); w++; end while (!(beat_valid_o && beat_idx_o == 4'd8) && w < 20);
    chk("rst_wait_idx8", 32'(beat_idx_o), 8);
    #1 rst_i = 1'b1;
    #1;
    chk("midrun_rst_ready", 32'(req_ready_o), 0);
    chk("midrun_rst_outs", 32'({beat_valid_o, lane_en_o, valu_ctrl_o, acc_clr_o, reduce_o, done_o, illegal_o, beat_idx_o}), 0);
    @(posedge clk_i); @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1 chk("midrun_ready_after", 32'(req_ready_o), 1);
    chk("midrun_no_beat", 32'(beat_valid_o), 0);
    repeat (2) @(posedge clk_i);
    #1;

    // masked add
`ifdef VALU_SEQ_MASK_EN
    mask_i = 16'h00F0;
    pb(0, 4'h0, 3'b010, 0, 0); pb(4, 4'hF, 3'b010, 0, 0); pd(0);
    run(F_ADDM, 5'd8, 0, 0, 3);
    mask_i = '0;
`else
    pd(1);
    run(F_ADDM, 5'd8, 0, 0, 1);
`endif

    repeat (3) @(posedge clk_i);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
